// File: rtl/sd_req_arbiter_if.sv
// Bundle of requester-side and engine-side signals around the SD request arbiter.
// The arbiter connects through the slave modport; the requesters plus engine
// (or a bench standing in for them) use the master modport.
interface sd_req_arbiter_if #(
    parameter int N_REQ = 6
);
    logic [N_REQ-1:0]    req_rd;
    logic [N_REQ-1:0]    req_wr;
    logic [32*N_REQ-1:0] req_lba;
    logic [8*N_REQ-1:0]  req_wr_data;
    logic [N_REQ-1:0]    req_busy;
    logic [N_REQ-1:0]    req_done;
    logic [N_REQ-1:0]    req_err;
    logic [N_REQ-1:0]    req_byte_strobe;
    logic [N_REQ-1:0]    grant;
    logic [31:0]         sd_lba;
    logic                sd_rd;
    logic                sd_wr;
    logic                sd_busy;
    logic                sd_done;
    logic                sd_rd_byte_strobe;
    logic [7:0]          sd_wr_data;

    modport slave (
        input  req_rd, req_wr, req_lba, req_wr_data,
        input  sd_busy, sd_done, sd_rd_byte_strobe,
        output req_busy, req_done, req_err, req_byte_strobe, grant,
        output sd_lba, sd_rd, sd_wr, sd_wr_data
    );

    modport master (
        output req_rd, req_wr, req_lba, req_wr_data,
        output sd_busy, sd_done, sd_rd_byte_strobe,
        input  req_busy, req_done, req_err, req_byte_strobe, grant,
        input  sd_lba, sd_rd, sd_wr, sd_wr_data
    );
endinterface

// File: rtl/sd_req_arbiter.sv
// Round-robin arbiter sharing one SD sector engine among N_REQ requesters.
// One sector transaction at a time: grant, issue, wait for done, release.
// A watchdog aborts a transaction the engine never finishes.
module sd_req_arbiter #(
    parameter int          N_REQ   = 6,
    parameter logic [23:0] TIMEOUT = 24'd12000000
) (
    input  logic            clk,
    input  logic            reset,
    sd_req_arbiter_if.slave bus
);
    localparam int PW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        RELEASE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [31:0]      sd_lba_q, sd_lba_d;
    logic             sd_rd_q, sd_rd_d;
    logic             sd_wr_q, sd_wr_d;
    logic [N_REQ-1:0] req_busy_q, req_busy_d;
    logic [N_REQ-1:0] req_done_q, req_done_d;
    logic [N_REQ-1:0] req_err_q, req_err_d;
    logic [PW-1:0]    rr_q, rr_d;
    logic [23:0]      timer_q, timer_d;

    logic [N_REQ-1:0] pending;
    logic             win_found;
    logic [N_REQ-1:0] win_oh;
    logic [PW-1:0]    win_next;
    logic [31:0]      win_lba;
    logic             win_wr;
    logic             timeout_hit;
    logic [23:0]      timer_inc;
    logic [7:0]       wr_data_mux;

    // Pick the first pending requester at or after the round-robin pointer.
    always_comb begin
        pending   = bus.req_rd | bus.req_wr;
        win_found = 1'b0;
        win_oh    = '0;
        win_next  = '0;
        win_lba   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!win_found && pending[i] && (i == ((int'(rr_q) + k) % N_REQ))) begin
                    win_found = 1'b1;
                    win_oh[i] = 1'b1;
                    win_next  = (i == N_REQ - 1) ? '0 : PW'(i + 1);
                end
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (win_oh[i]) begin
                win_lba = bus.req_lba[32*i +: 32];
            end
        end
        // A write wins over a read from the same requester; the read stays pending.
        win_wr = |(win_oh & bus.req_wr);
    end

    // Transaction sequencing, watchdog and registered handshake outputs.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        sd_lba_d    = sd_lba_q;
        sd_rd_d     = sd_rd_q;
        sd_wr_d     = sd_wr_q;
        req_busy_d  = req_busy_q;
        req_done_d  = '0;
        req_err_d   = '0;
        rr_d        = rr_q;
        timer_d     = timer_q;
        timeout_hit = (timer_q == TIMEOUT - 24'd1);
        timer_inc   = (timer_q == '1) ? timer_q : timer_q + 24'd1;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_d  = win_oh;
                    sd_lba_d = win_lba;
                    sd_rd_d  = !win_wr;
                    sd_wr_d  = win_wr;
                    rr_d     = win_next;
                    timer_d  = '0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = timer_inc;
                if (bus.sd_busy && bus.sd_done) begin
                    // Engine accepted and finished in one cycle: complete directly.
                    sd_rd_d    = 1'b0;
                    sd_wr_d    = 1'b0;
                    req_done_d = grant_q;
                    state_d    = RELEASE;
                end else if (timeout_hit) begin
                    sd_rd_d   = 1'b0;
                    sd_wr_d   = 1'b0;
                    req_err_d = grant_q;
                    state_d   = RELEASE;
                end else if (bus.sd_busy) begin
                    sd_rd_d    = 1'b0;
                    sd_wr_d    = 1'b0;
                    req_busy_d = grant_q;
                    state_d    = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                timer_d = timer_inc;
                if (bus.sd_done) begin
                    req_done_d = grant_q;
                    req_busy_d = '0;
                    state_d    = RELEASE;
                end else if (timeout_hit) begin
                    req_err_d  = grant_q;
                    req_busy_d = '0;
                    state_d    = RELEASE;
                end
            end
            RELEASE: begin
                // Dropping grant here leaves one idle cycle between owners.
                grant_d = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; synchronous reset abandons any transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            sd_lba_q   <= '0;
            sd_rd_q    <= 1'b0;
            sd_wr_q    <= 1'b0;
            req_busy_q <= '0;
            req_done_q <= '0;
            req_err_q  <= '0;
            rr_q       <= '0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            sd_lba_q   <= sd_lba_d;
            sd_rd_q    <= sd_rd_d;
            sd_wr_q    <= sd_wr_d;
            req_busy_q <= req_busy_d;
            req_done_q <= req_done_d;
            req_err_q  <= req_err_d;
            rr_q       <= rr_d;
            timer_q    <= timer_d;
        end
    end

    // Write-data mux follows the current owner; zero while nobody holds the grant.
    always_comb begin
        wr_data_mux = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                wr_data_mux = wr_data_mux | bus.req_wr_data[8*i +: 8];
            end
        end
    end

    assign bus.grant           = grant_q;
    assign bus.sd_lba          = sd_lba_q;
    assign bus.sd_rd           = sd_rd_q;
    assign bus.sd_wr           = sd_wr_q;
    assign bus.req_busy        = req_busy_q;
    assign bus.req_done        = req_done_q;
    assign bus.req_err         = req_err_q;
    assign bus.sd_wr_data      = wr_data_mux;
    assign bus.req_byte_strobe = {N_REQ{bus.sd_rd_byte_strobe && (state_q == WAIT_DONE)}} & grant_q;

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Bench for sd_req_arbiter: directed scenarios followed by randomized
// transactions, all predicted by a transaction-level round-robin model.
module tb_sd_req_arbiter;
    localparam int N   = 6;
    localparam int TMO = 1000;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   rr_m   = 0;

    sd_req_arbiter_if #(.N_REQ(N)) bus ();

    sd_req_arbiter #(.N_REQ(N), .TIMEOUT(24'(TMO))) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference arbitration: first pending index from the pointer, wrapping.
    function automatic int model_pick(input logic [N-1:0] pend);
        logic [N-1:0] s;
        for (int k = 0; k < N; k++) begin
            s = pend >> ((rr_m + k) % N);
            if (s[0]) return (rr_m + k) % N;
        end
        return -1;
    endfunction

    task automatic drop_op(input logic [N-1:0] oh, input bit op_wr);
        if (op_wr) bus.req_wr = bus.req_wr & ~oh;
        else       bus.req_rd = bus.req_rd & ~oh;
    endtask

    // One full transaction with the bench acting as the SD engine.
    task automatic run_txn(input int bdelay, input bit same_done, input int wlen, input int pct,
                           input bit hang, input bit drop, input bit early,
                           output int w, output bit wr_seen, output int gap);
        logic [N-1:0] pend, oh, tmp;
        logic [31:0]  lba_e;
        bit           op_wr, sb;
        int           t, sb_cnt, sb_got;
        pend = bus.req_rd | bus.req_wr;
        gap  = 0;
        while (bus.grant == '0 && gap < 20) begin
            tick();
            gap++;
        end
        chk("grant_seen", 64'(bus.grant != '0), 64'd1);
        w = model_pick(pend);
        if (w < 0) w = 0;
        rr_m    = (w + 1) % N;
        oh      = N'(1) << w;
        tmp     = bus.req_wr >> w;
        op_wr   = tmp[0];
        lba_e   = 32'(bus.req_lba >> (32 * w));
        wr_seen = bus.sd_wr;
        chk("grant", 64'(bus.grant), 64'(oh));
        chk("sd_lba", 64'(bus.sd_lba), 64'(lba_e));
        chk("sd_rd", 64'(bus.sd_rd), 64'(!op_wr));
        chk("sd_wr", 64'(bus.sd_wr), 64'(op_wr));
        chk("wr_data", 64'(bus.sd_wr_data), 64'(8'(bus.req_wr_data >> (8 * w))));
        t = 0;
        if (early) begin
            drop_op(oh, op_wr);
            bus.req_lba = bus.req_lba ^ ((32*N)'(32'hFFFF_FFFF) << (32 * w));
        end
        repeat (bdelay) begin
            tick();
            t++;
            chk("issue_rdwr", 64'({bus.sd_rd, bus.sd_wr}), 64'({!op_wr, op_wr}));
            chk("issue_busy", 64'(bus.req_busy), 64'd0);
        end
        bus.sd_busy = 1'b1;
        bus.sd_done = same_done && !hang;
        tick();
        t++;
        if (same_done && !hang) begin
            chk("done_first", 64'(bus.req_done), 64'(oh));
            chk("busy_skip", 64'(bus.req_busy), 64'd0);
            chk("rdwr_drop", 64'({bus.sd_rd, bus.sd_wr}), 64'd0);
        end else begin
            chk("req_busy", 64'(bus.req_busy), 64'(oh));
            chk("rdwr_drop", 64'({bus.sd_rd, bus.sd_wr}), 64'd0);
            chk("no_done", 64'(bus.req_done), 64'd0);
        end
        bus.sd_done = 1'b0;
        if (drop && !early) drop_op(oh, op_wr);
        if (hang) begin
            while (t < TMO - 1) begin
                tick();
                t++;
            end
            chk("err_early", 64'(bus.req_err), 64'd0);
            tick();
            t++;
            chk("err", 64'(bus.req_err), 64'(oh));
            chk("err_no_done", 64'(bus.req_done), 64'd0);
            chk("err_busy", 64'(bus.req_busy), 64'd0);
            chk("err_rdwr", 64'({bus.sd_rd, bus.sd_wr}), 64'd0);
            bus.sd_busy = 1'b0;
        end else if (!same_done) begin
            sb_cnt = 0;
            sb_got = 0;
            repeat (wlen) begin
                sb = ($urandom_range(99) < pct);
                bus.sd_rd_byte_strobe = sb;
                #1;
                chk("strobe_route", 64'(bus.req_byte_strobe), sb ? 64'(oh) : 64'd0);
                sb_cnt += int'(sb);
                sb_got += int'((bus.req_byte_strobe & oh) != '0);
                tick();
                t++;
            end
            bus.sd_rd_byte_strobe = 1'b0;
            chk("strobe_cnt", 64'(sb_got), 64'(sb_cnt));
            bus.sd_done = 1'b1;
            tick();
            t++;
            chk("done", 64'(bus.req_done), 64'(oh));
            chk("done_no_err", 64'(bus.req_err), 64'd0);
            chk("done_busy", 64'(bus.req_busy), 64'd0);
            chk("lba_hold", 64'(bus.sd_lba), 64'(lba_e));
            chk("release_grant", 64'(bus.grant), 64'(oh));
            bus.sd_done = 1'b0;
            bus.sd_busy = 1'b0;
        end else begin
            bus.sd_busy = 1'b0;
        end
        tick();
        chk("gap_grant", 64'(bus.grant), 64'd0);
        chk("pulse_end", 64'({bus.req_done, bus.req_err}), 64'd0);
    endtask

    initial begin
        int w, w1, gap, n;
        bit wr_seen;
        int rr_exp [4] = '{0, 2, 4, 0};
        logic [32*N-1:0] lb;
        logic [8*N-1:0]  wd;

        reset = 1'b1;
        bus.req_rd = '0;
        bus.req_wr = '0;
        bus.req_lba = '0;
        bus.req_wr_data = '0;
        bus.sd_busy = 1'b0;
        bus.sd_done = 1'b0;
        bus.sd_rd_byte_strobe = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_grant", 64'(bus.grant), 64'd0);
        chk("rst_rdwr", 64'({bus.sd_rd, bus.sd_wr}), 64'd0);
        chk("rst_lba", 64'(bus.sd_lba), 64'd0);
        chk("rst_pulses", 64'({bus.req_busy, bus.req_done, bus.req_err}), 64'd0);
        chk("rst_wr_data", 64'(bus.sd_wr_data), 64'd0);

        // Engine activity while idle must not leak to any requester.
        bus.sd_rd_byte_strobe = 1'b1;
        bus.sd_done = 1'b1;
        #1;
        chk("idle_strobe", 64'(bus.req_byte_strobe), 64'd0);
        repeat (3) begin
            tick();
            chk("idle_done", 64'({bus.req_done, bus.req_busy, bus.grant}), 64'd0);
        end
        bus.sd_rd_byte_strobe = 1'b0;
        bus.sd_done = 1'b0;

        // Round robin among 0, 2, 4 held continuously.
        bus.req_lba = {32'h5000_0005, 32'h4000_0004, 32'h3000_0003,
                       32'h2000_0002, 32'h1000_0001, 32'h0000_0100};
        bus.req_wr_data = 48'hA5_96_87_78_69_5A;
        bus.req_rd = 6'b010101;
        for (int i = 0; i < 4; i++) begin
            run_txn(1, 1'b0, 3, 0, 1'b0, 1'b0, 1'b0, w, wr_seen, gap);
            chk("rr_order", 64'(w), 64'(rr_exp[i]));
            chk("rr_gap", 64'(gap), 64'd1);
        end
        bus.req_rd = '0;

        // Single read from requester 1, slow engine.
        bus.req_lba = (32*N)'(32'h0000_0010) << 32;
        bus.req_rd = 6'b000010;
        run_txn(3, 1'b0, 600, 0, 1'b0, 1'b1, 1'b0, w, wr_seen, gap);
        chk("single_w", 64'(w), 64'd1);

        // Read and write from requester 3: write first, then the held read.
        bus.req_rd = 6'b001000;
        bus.req_wr = 6'b001000;
        run_txn(1, 1'b0, 4, 0, 1'b0, 1'b1, 1'b0, w, wr_seen, gap);
        chk("rw_first_wr", 64'(wr_seen), 64'd1);
        run_txn(1, 1'b0, 4, 0, 1'b0, 1'b1, 1'b0, w, wr_seen, gap);
        chk("rw_second_rd", 64'(wr_seen), 64'd0);
        chk("rw_second_w", 64'(w), 64'd3);

        // Full sector of byte strobes to requester 2.
        bus.req_rd = 6'b000100;
        run_txn(0, 1'b0, 512, 100, 1'b0, 1'b1, 1'b0, w, wr_seen, gap);
        chk("strobe_w", 64'(w), 64'd2);

        // Watchdog on a hung engine, then the other pending requester is served.
        bus.req_rd = 6'b100010;
        run_txn(2, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0, w1, wr_seen, gap);
        run_txn(1, 1'b0, 2, 0, 1'b0, 1'b1, 1'b0, w, wr_seen, gap);
        chk("wd_next", 64'(w), (w1 == 1) ? 64'd5 : 64'd1);

        // Same-cycle busy and done.
        bus.req_wr = 6'b000001;
        run_txn(0, 1'b1, 0, 0, 1'b0, 1'b1, 1'b0, w, wr_seen, gap);
        chk("fast_w", 64'(w), 64'd0);

        // Reset in the middle of a transfer.
        bus.req_lba = (32*N)'(32'hDEAD_0004) << 128;
        bus.req_rd = 6'b010000;
        n = 0;
        while (bus.grant == '0 && n < 20) begin
            tick();
            n++;
        end
        bus.sd_busy = 1'b1;
        tick();
        chk("mid_busy", 64'(bus.req_busy), 64'h10);
        bus.sd_rd_byte_strobe = 1'b1;
        reset = 1'b1;
        tick();
        chk("mid_rst_grant", 64'(bus.grant), 64'd0);
        chk("mid_rst_rdwr", 64'({bus.sd_rd, bus.sd_wr}), 64'd0);
        chk("mid_rst_lba", 64'(bus.sd_lba), 64'd0);
        chk("mid_rst_pulses", 64'({bus.req_busy, bus.req_done, bus.req_err, bus.req_byte_strobe}), 64'd0);
        reset = 1'b0;
        bus.sd_busy = 1'b0;
        bus.sd_rd_byte_strobe = 1'b0;
        rr_m = 0;
        bus.req_rd = 6'b010010;
        run_txn(1, 1'b0, 2, 0, 1'b0, 1'b1, 1'b0, w, wr_seen, gap);
        chk("post_rst_w", 64'(w), 64'd1);

        // Randomized traffic against the model.
        for (int r = 0; r < 40; r++) begin
            lb = '0;
            wd = '0;
            for (int i = 0; i < N; i++) begin
                lb = (lb << 32) | (32*N)'($urandom);
                wd = (wd << 8) | (8*N)'($urandom_range(255));
            end
            bus.req_lba = lb;
            bus.req_wr_data = wd;
            bus.req_rd = bus.req_rd | (N'($urandom) & N'($urandom));
            bus.req_wr = bus.req_wr | (N'($urandom) & N'($urandom) & N'($urandom));
            if ((bus.req_rd | bus.req_wr) == '0) bus.req_rd = N'(1) << $urandom_range(N - 1);
            run_txn($urandom_range(3), $urandom_range(7) == 0, $urandom_range(20), 50,
                    $urandom_range(14) == 0, 1'b1, $urandom_range(3) == 0, w, wr_seen, gap);
            chk("rand_gap", 64'(gap), 64'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL global_timeout: bench did not finish, got %0d checks, expected completion", n_chk);
        $fatal(1, "bench timeout");
    end
endmodule

// File: doc/sd_req_arbiter.md
Name: sd_req_arbiter

Overview:
- Shares the single SD sector engine (one lba, rd, wr, busy, done, byte-strobe interface) among N requesters, e.g. the c1541 drive, the image loader and the save path.
- Grants one sector transaction at a time using round-robin and latches the winner's LBA and operation.
- Routes busy, done and byte strobes back to the granted requester only, and muxes that requester's write data to the engine.
- A watchdog aborts a transaction the engine never completes.

Parameters:
N_REQ, 6, number of requesters (2..8)
TIMEOUT, 24'd12000000, cycles allowed from issue to sd_done before abort

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
req_rd  in  N_REQ  per-requester read request, level; held until req_busy seen
req_wr  in  N_REQ  per-requester write request, level; held until req_busy seen
req_lba  in  32*N_REQ  flat LBA bus; requester i uses bits [32*i+31:32*i]
req_wr_data  in  8*N_REQ  flat write-data bus, same slicing
req_busy  out  N_REQ  onehot; granted requester's transaction accepted by engine
req_done  out  N_REQ  one-cycle pulse, transaction complete
req_err  out  N_REQ  one-cycle pulse, transaction aborted by watchdog
req_byte_strobe  out  N_REQ  sd_rd_byte_strobe gated to granted requester
grant  out  N_REQ  onehot current owner, 0 when idle
sd_lba  out  32  latched LBA to engine
sd_rd  out  1  read request to engine
sd_wr  out  1  write request to engine
sd_busy  in  1  engine accepted request / transfer in progress
sd_done  in  1  engine finished sector
sd_rd_byte_strobe  in  1  engine delivered one read byte
sd_wr_data  out  8  req_wr_data slice of granted requester (combinational)

Behaviour:
- Reset values: grant=0, sd_rd=0, sd_wr=0, sd_lba=0, req_busy=0, req_done=0, req_err=0, rr pointer=0, timer=0, state=IDLE. Reset mid-transaction drops sd_rd/sd_wr immediately. Nothing is replayed.
- pending[i] = req_rd[i] | req_wr[i].
- IDLE:
  - If any pending, winner = first pending index scanning from rr_ptr upward, wrapping at N_REQ.
  - Register grant=onehot(winner), sd_lba=winner's slice, op=wr if req_wr[winner] else rd. Write wins when both are set; the rd stays pending for a later grant.
  - rr_ptr = (winner+1) mod N_REQ. timer=0. Go to ISSUE.
  - Grant is visible the cycle after the request is sampled.
- ISSUE:
  - sd_rd or sd_wr (per op) = 1.
  - On sd_busy=1: clear sd_rd/sd_wr next cycle, req_busy=grant, go to WAIT_DONE.
- WAIT_DONE:
  - On sd_done=1: req_done=grant for exactly one cycle, req_busy=0, go to RELEASE.
  - sd_done arriving in the same cycle as the first sd_busy is honoured, with done taking precedence (req_done pulses directly).
- RELEASE: grant=0 for one cycle, then IDLE. This guarantees a gap cycle between owners.
- Watchdog:
  - timer increments in ISSUE and WAIT_DONE and saturates.
  - When timer==TIMEOUT-1 and no sd_done this cycle: sd_rd/sd_wr=0, req_err=grant for one pulse, req_busy=0, go to RELEASE. sd_done in that same cycle wins over the abort.
- Routing (combinational):
  - req_byte_strobe[i] = sd_rd_byte_strobe & grant[i] & (state==WAIT_DONE).
  - sd_wr_data = req_wr_data slice selected by grant; 0 when grant=0.
- Requests changing after grant do not alter sd_lba or op. A requester dropping its request before req_busy does not cancel the grant; the transaction completes.
- sd_done or sd_rd_byte_strobe arriving in IDLE is ignored and produces no pulses.
- Fairness: a continuously requesting requester waits at most N_REQ-1 transactions.

Test Plan:
- Single request: req_rd[1]=1, lba1=0x00000010; engine raises busy 3 cycles after sd_rd, done 600 cycles later -> grant=0b000010, sd_lba=0x10, sd_rd drops the cycle after busy, req_done[1] pulses once, grant=0 one cycle after.
- Round-robin: req_rd[0], req_rd[2] and req_rd[4] held continuously -> grant order 0,2,4,0; one idle-grant cycle between each pair.
- Read+write same requester: req_rd[3]=req_wr[3]=1 -> first transaction has sd_wr=1; second, with req_rd[3] still held, has sd_rd=1.
- Strobe gating: grant=2, 512 sd_rd_byte_strobe pulses -> req_byte_strobe[2] pulses 512 times, all other bits 0; strobe injected in IDLE -> no output pulse.
- Watchdog: TIMEOUT=100, engine raises busy but never done -> req_err pulses 100 cycles after issue, sd_rd=0, no req_done; the next pending requester is then granted.
- Reset mid-transfer: reset asserted in WAIT_DONE -> next cycle all outputs 0; a later request is served starting from rr_ptr=0.
